// File: rtl/imem_responder_if.sv
// imem_responder_if
//   Bundles the fetch port and the program-load stream of the instruction
//   memory responder.
//   Fetch side : imem_address_i (64b byte address), imem_instruction_o (32b),
//                imem_ready_o, misaligned_o, fault_o.
//   Load side  : load_start_i, load_base_i (64b), load_valid_i, load_data_i,
//                load_last_i, load_ready_o, load_count_o (IDX_W+1 bits).
//   Modports   : slave  = the responder, master = fetch stage / host loader.
//   Signal suffixes are written from the responder's point of view.
interface imem_responder_if #(
  parameter int DEPTH_WORDS = 1024
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [63:0]    imem_address_i;
  logic [31:0]    imem_instruction_o;
  logic           imem_ready_o;
  logic           misaligned_o;
  logic           fault_o;
  logic           load_start_i;
  logic [63:0]    load_base_i;
  logic           load_valid_i;
  logic [31:0]    load_data_i;
  logic           load_last_i;
  logic           load_ready_o;
  logic [IDX_W:0] load_count_o;

  modport slave (
    input  imem_address_i, load_start_i, load_base_i, load_valid_i,
           load_data_i, load_last_i,
    output imem_instruction_o, imem_ready_o, misaligned_o, fault_o,
           load_ready_o, load_count_o
  );

  modport master (
    output imem_address_i, load_start_i, load_base_i, load_valid_i,
           load_data_i, load_last_i,
    input  imem_instruction_o, imem_ready_o, misaligned_o, fault_o,
           load_ready_o, load_count_o
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction memory for the fetch stage plus its program-load path.
//   Ports:
//     clk   - sole clock, all state on posedge
//     reset - synchronous, active-low
//     bus   - imem_responder_if.slave (fetch port + load stream)
//   Behaviour: IDLE -> (load_start) -> LOAD -> (accepted word with last) -> RUN.
//   RUN serves combinational reads; load_start in RUN re-enters LOAD.
//   Reads outside RUN, misaligned or out of range return NOP.
//   Optional feature macro: IMEM_BOUNDS_CHECK_EN
//     defined   - fetches at or above DEPTH_WORDS*4 return NOP and set a
//                 sticky fault_o (cleared only by reset)
//     undefined - upper address bits ignored (index aliases), fault_o = 0
//   The array is never cleared by reset.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus
);

  localparam logic [31:0]    NOP       = 32'hD503201F;
  localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_MAX   = (IDX_W+1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             mem_we_s;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] base_idx_s;
  logic             misaligned_s;
  logic             oob_s;
  logic [31:0]      instr_s;

  assign rd_idx_s     = bus.imem_address_i[IDX_W+1:2];
  assign base_idx_s   = bus.load_base_i[IDX_W+1:2];
  assign misaligned_s = |bus.imem_address_i[1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic fault_q, fault_d;

  // Any address bit above the array span means the fetch is out of range.
  assign oob_s = |bus.imem_address_i[63:IDX_W+2];

  // Sticky fault: set by an out-of-range fetch in RUN, cleared only by reset.
  always_comb begin
    fault_d = fault_q;
    if (state_q == ST_RUN && oob_s) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault flag register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign bus.fault_o = fault_q;
  logic unused_addr_s;
  assign unused_addr_s = ^{bus.load_base_i[63:IDX_W+2], bus.load_base_i[1:0]};
`else
  // Upper bits are deliberately ignored so the index aliases.
  assign oob_s       = 1'b0;
  assign bus.fault_o = 1'b0;
  logic unused_addr_s;
  assign unused_addr_s = ^{bus.imem_address_i[63:IDX_W+2],
                           bus.load_base_i[63:IDX_W+2], bus.load_base_i[1:0]};
`endif

  // Next-state logic for the load/run FSM, write pointer and word count.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start_i) begin
          state_d = ST_LOAD;
          ptr_d   = base_idx_s;
          count_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // load_start_i is intentionally ignored while a load is in progress.
        if (bus.load_valid_i) begin
          mem_we_s = 1'b1;
          ptr_d    = ptr_q + PTR_ONE;   // wraps modulo DEPTH_WORDS
          count_d  = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);
          if (bus.load_last_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (bus.load_start_i) begin
          state_d = ST_LOAD;
          ptr_d   = base_idx_s;
          count_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, pointer and count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Program array write port; contents survive reset, but no write lands
  // on a reset edge so an aborted load stops cleanly.
  always_ff @(posedge clk) begin
    if (reset && mem_we_s) begin
      mem_q[ptr_q] <= bus.load_data_i;
    end
  end

  // Zero-latency read: only a clean, in-range fetch in RUN sees the array.
  always_comb begin
    instr_s = NOP;
    if (state_q == ST_RUN && !misaligned_s && !oob_s) begin
      instr_s = mem_q[rd_idx_s];
    end else begin
      instr_s = NOP;
    end
  end

  assign bus.imem_instruction_o = instr_s;
  assign bus.misaligned_o       = misaligned_s;
  assign bus.imem_ready_o       = (state_q == ST_RUN);
  assign bus.load_ready_o       = (state_q == ST_LOAD);
  assign bus.load_count_o       = count_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Directed testbench for imem_responder: reset state, program load,
//   pointer wrap, misalignment, reload, out-of-range fetch, reset abort and
//   count saturation. Inputs change 1 time unit after posedge; outputs are
//   sampled at least 1 time unit after that, away from the clock edge.
module tb_imem_responder;

  localparam int D = 1024;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  imem_responder_if #(.DEPTH_WORDS(D)) bus ();

  imem_responder #(.DEPTH_WORDS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.imem_address_i = 64'd0;
    bus.load_start_i = 1'b0;
    bus.load_base_i = 64'd0;
    bus.load_valid_i = 1'b0;
    bus.load_data_i = 32'd0;
    bus.load_last_i = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (bus.imem_ready_o !== 1'b0) begin errors++; $display("FAIL reset_imem_ready got=%0b exp=0", bus.imem_ready_o); end
    checks++; if (bus.load_ready_o !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%0b exp=0", bus.load_ready_o); end
    checks++; if (bus.load_count_o !== 11'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.load_count_o); end
    checks++; if (bus.imem_instruction_o !== NOP) begin errors++; $display("FAIL reset_nop got=%h exp=%h", bus.imem_instruction_o, NOP); end
    checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault got=%0b exp=0", bus.fault_o); end
    bus.imem_address_i = 64'd2;
    #1;
    checks++; if (bus.misaligned_o !== 1'b1) begin errors++; $display("FAIL reset_misaligned got=%0b exp=1", bus.misaligned_o); end
    bus.imem_address_i = 64'd0;
    #1;
  endtask

  task automatic test_load();
    logic [31:0] w [3];
    w[0] = 32'h91000421; w[1] = 32'h8B020020; w[2] = 32'h0B400004;
    bus.load_base_i = 64'd0;
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    #1;
    checks++; if (bus.load_ready_o !== 1'b1) begin errors++; $display("FAIL load_ready got=%0b exp=1", bus.load_ready_o); end
    for (int i = 0; i < 3; i++) begin
      bus.load_valid_i = 1'b1;
      bus.load_data_i = w[i];
      bus.load_last_i = (i == 2);
      if (i == 2) begin
        // Still in LOAD here: reads must give NOP even for written words.
        checks++; if (bus.imem_instruction_o !== NOP) begin errors++; $display("FAIL load_read_nop got=%h exp=%h", bus.imem_instruction_o, NOP); end
      end
      tick();
    end
    bus.load_valid_i = 1'b0;
    bus.load_last_i = 1'b0;
    #1;
    checks++; if (bus.load_count_o !== 11'd3) begin errors++; $display("FAIL load_count got=%0d exp=3", bus.load_count_o); end
    checks++; if (bus.imem_ready_o !== 1'b1) begin errors++; $display("FAIL load_imem_ready got=%0b exp=1", bus.imem_ready_o); end
    checks++; if (bus.load_ready_o !== 1'b0) begin errors++; $display("FAIL load_ready_run got=%0b exp=0", bus.load_ready_o); end
    for (int i = 0; i < 3; i++) begin
      bus.imem_address_i = 64'(i * 4);
      #1;
      checks++; if (bus.imem_instruction_o !== w[i]) begin errors++; $display("FAIL load_read%0d got=%h exp=%h", i, bus.imem_instruction_o, w[i]); end
    end
    // Valid without ready in RUN is dropped.
    bus.load_valid_i = 1'b1;
    bus.load_data_i = 32'hDEADBEEF;
    tick();
    bus.load_valid_i = 1'b0;
    bus.imem_address_i = 64'd0;
    #1;
    checks++; if (bus.load_count_o !== 11'd3) begin errors++; $display("FAIL drop_count got=%0d exp=3", bus.load_count_o); end
    checks++; if (bus.imem_instruction_o !== 32'h91000421) begin errors++; $display("FAIL drop_data got=%h exp=91000421", bus.imem_instruction_o); end
  endtask

  task automatic test_misaligned();
    bus.imem_address_i = 64'd6;
    #1;
    checks++; if (bus.misaligned_o !== 1'b1) begin errors++; $display("FAIL mis6_flag got=%0b exp=1", bus.misaligned_o); end
    checks++; if (bus.imem_instruction_o !== NOP) begin errors++; $display("FAIL mis6_nop got=%h exp=%h", bus.imem_instruction_o, NOP); end
    bus.imem_address_i = 64'd8;
    #1;
    checks++; if (bus.misaligned_o !== 1'b0) begin errors++; $display("FAIL mis8_flag got=%0b exp=0", bus.misaligned_o); end
    checks++; if (bus.imem_instruction_o !== 32'h0B400004) begin errors++; $display("FAIL mis8_data got=%h exp=0b400004", bus.imem_instruction_o); end
  endtask

  task automatic test_wrap();
    bus.load_base_i = 64'((D - 1) * 4);
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    bus.imem_address_i = 64'd0;
    #1;
    checks++; if (bus.imem_ready_o !== 1'b0) begin errors++; $display("FAIL wrap_ready_drop got=%0b exp=0", bus.imem_ready_o); end
    bus.load_valid_i = 1'b1;
    bus.load_data_i = 32'hAAAA0001;
    bus.load_last_i = 1'b0;
    tick();
    bus.load_data_i = 32'hAAAA0002;
    bus.load_last_i = 1'b1;
    tick();
    bus.load_valid_i = 1'b0;
    bus.load_last_i = 1'b0;
    bus.imem_address_i = 64'((D - 1) * 4);
    #1;
    checks++; if (bus.imem_instruction_o !== 32'hAAAA0001) begin errors++; $display("FAIL wrap_top got=%h exp=aaaa0001", bus.imem_instruction_o); end
    bus.imem_address_i = 64'd0;
    #1;
    checks++; if (bus.imem_instruction_o !== 32'hAAAA0002) begin errors++; $display("FAIL wrap_zero got=%h exp=aaaa0002", bus.imem_instruction_o); end
    bus.imem_address_i = 64'd4;
    #1;
    checks++; if (bus.imem_instruction_o !== 32'h8B020020) begin errors++; $display("FAIL wrap_keep got=%h exp=8b020020", bus.imem_instruction_o); end
    checks++; if (bus.load_count_o !== 11'd2) begin errors++; $display("FAIL wrap_count got=%0d exp=2", bus.load_count_o); end
  endtask

  task automatic test_reload();
    bus.load_base_i = 64'h100;
    bus.load_start_i = 1'b1;
    bus.load_valid_i = 1'b0;
    tick();
    bus.load_start_i = 1'b0;
    bus.imem_address_i = 64'd8;
    #1;
    checks++; if (bus.imem_ready_o !== 1'b0) begin errors++; $display("FAIL reload_ready got=%0b exp=0", bus.imem_ready_o); end
    checks++; if (bus.imem_instruction_o !== NOP) begin errors++; $display("FAIL reload_nop got=%h exp=%h", bus.imem_instruction_o, NOP); end
    checks++; if (bus.load_count_o !== 11'd0) begin errors++; $display("FAIL reload_count0 got=%0d exp=0", bus.load_count_o); end
    // A second start in LOAD must not move the pointer.
    bus.load_base_i = 64'h200;
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b1;
    bus.load_data_i = 32'h12345678;
    bus.load_last_i = 1'b1;
    tick();
    bus.load_valid_i = 1'b0;
    bus.load_last_i = 1'b0;
    bus.imem_address_i = 64'h100;
    #1;
    checks++; if (bus.imem_ready_o !== 1'b1) begin errors++; $display("FAIL reload_run got=%0b exp=1", bus.imem_ready_o); end
    checks++; if (bus.load_count_o !== 11'd1) begin errors++; $display("FAIL reload_count got=%0d exp=1", bus.load_count_o); end
    checks++; if (bus.imem_instruction_o !== 32'h12345678) begin errors++; $display("FAIL reload_data got=%h exp=12345678", bus.imem_instruction_o); end
  endtask

  task automatic test_oob();
    checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL oob_fault_pre got=%0b exp=0", bus.fault_o); end
    bus.imem_address_i = 64'(D * 4);
    #1;
`ifdef IMEM_BOUNDS_CHECK_EN
    checks++; if (bus.imem_instruction_o !== NOP) begin errors++; $display("FAIL oob_nop got=%h exp=%h", bus.imem_instruction_o, NOP); end
`else
    checks++; if (bus.imem_instruction_o !== 32'hAAAA0002) begin errors++; $display("FAIL oob_alias got=%h exp=aaaa0002", bus.imem_instruction_o); end
`endif
    tick();
    bus.imem_address_i = 64'd0;
    tick();
`ifdef IMEM_BOUNDS_CHECK_EN
    checks++; if (bus.fault_o !== 1'b1) begin errors++; $display("FAIL oob_fault got=%0b exp=1", bus.fault_o); end
`else
    checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL oob_fault got=%0b exp=0", bus.fault_o); end
`endif
    checks++; if (bus.imem_instruction_o !== 32'hAAAA0002) begin errors++; $display("FAIL oob_after got=%h exp=aaaa0002", bus.imem_instruction_o); end
  endtask

  task automatic test_reset_abort();
    bus.load_base_i = 64'h40;
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b1;
    bus.load_data_i = 32'hCAFE0001;
    bus.load_last_i = 1'b0;
    tick();
    bus.load_valid_i = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.load_ready_o !== 1'b0) begin errors++; $display("FAIL abort_load_ready got=%0b exp=0", bus.load_ready_o); end
    checks++; if (bus.load_count_o !== 11'd0) begin errors++; $display("FAIL abort_count got=%0d exp=0", bus.load_count_o); end
    checks++; if (bus.fault_o !== 1'b0) begin errors++; $display("FAIL abort_fault got=%0b exp=0", bus.fault_o); end
    bus.load_base_i = 64'h44;
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b1;
    bus.load_data_i = 32'hBEEF0002;
    bus.load_last_i = 1'b1;
    tick();
    bus.load_valid_i = 1'b0;
    bus.load_last_i = 1'b0;
    bus.imem_address_i = 64'h40;
    #1;
    checks++; if (bus.imem_instruction_o !== 32'hCAFE0001) begin errors++; $display("FAIL abort_kept got=%h exp=cafe0001", bus.imem_instruction_o); end
    bus.imem_address_i = 64'h44;
    #1;
    checks++; if (bus.imem_instruction_o !== 32'hBEEF0002) begin errors++; $display("FAIL abort_new got=%h exp=beef0002", bus.imem_instruction_o); end
  endtask

  task automatic test_saturate();
    bus.load_base_i = 64'd0;
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    for (int i = 0; i < D; i++) begin
      bus.load_valid_i = 1'b1;
      bus.load_data_i = 32'(i);
      bus.load_last_i = 1'b0;
      tick();
    end
    checks++; if (bus.load_count_o !== 11'd1024) begin errors++; $display("FAIL sat_full got=%0d exp=1024", bus.load_count_o); end
    bus.load_data_i = 32'd1024;
    bus.load_last_i = 1'b1;
    tick();
    bus.load_valid_i = 1'b0;
    bus.load_last_i = 1'b0;
    bus.imem_address_i = 64'd0;
    #1;
    checks++; if (bus.load_count_o !== 11'd1024) begin errors++; $display("FAIL sat_hold got=%0d exp=1024", bus.load_count_o); end
    checks++; if (bus.imem_instruction_o !== 32'd1024) begin errors++; $display("FAIL sat_word0 got=%h exp=00000400", bus.imem_instruction_o); end
    bus.imem_address_i = 64'd4;
    #1;
    checks++; if (bus.imem_instruction_o !== 32'd1) begin errors++; $display("FAIL sat_word1 got=%h exp=00000001", bus.imem_instruction_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load();
    test_misaligned();
    test_wrap();
    test_reload();
    test_oob();
    test_reset_abort();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
